// File: rtl/penc_pkg.sv
// Shared types and helpers for the pipelined priority encoder.
// Build option: PENC_MULTI_HIT_EN adds the multi-hit field to every node.
package penc_pkg;

    // Widest index any configuration may carry through the merge tree.
    localparam int IW_MAX = 16;

    typedef struct packed {
        logic              hit;
`ifdef PENC_MULTI_HIT_EN
        logic              multi;
`endif
        logic [IW_MAX-1:0] idx;
    } penc_node_t;

    function automatic int penc_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Index port width: clog2 of the word width, never narrower than one bit.
    function automatic int penc_idx_width(input int n);
        int r;
        r = penc_clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Combine a lower-index group a with a higher-index group b.
    // An empty node always carries idx=0, so two empty groups stay at 0.
    function automatic penc_node_t penc_merge(input penc_node_t a,
                                              input penc_node_t b,
                                              input bit         msb_first);
        penc_node_t n;
        n     = '0;
        n.hit = a.hit | b.hit;
        if (msb_first) begin
            n.idx = b.hit ? b.idx : a.idx;
        end else begin
            n.idx = a.hit ? a.idx : b.idx;
        end
`ifdef PENC_MULTI_HIT_EN
        n.multi = a.multi | b.multi | (a.hit & b.hit);
`endif
        return n;
    endfunction

endpackage

// File: rtl/penc_seg.sv
// Combinational encoder for one SEG-bit segment; produces a node whose idx is
// already global (segment base + local winner), or 0 when the segment is empty.
// Build option: PENC_MULTI_HIT_EN also reports more-than-one-bit-set.
module penc_seg
    import penc_pkg::*;
#(
    parameter int SEG       = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic [SEG-1:0]    i_seg,
    input  logic [IW_MAX-1:0] i_base,
    output penc_node_t        o_node
);

    logic              w_hit;
    logic [IW_MAX-1:0] w_loc;
`ifdef PENC_MULTI_HIT_EN
    logic              w_multi;
`endif

    // Scan bits in priority order: the first set bit wins, any later set bit is a second hit.
    always_comb begin
        w_hit = 1'b0;
        w_loc = '0;
`ifdef PENC_MULTI_HIT_EN
        w_multi = 1'b0;
`endif
        for (int k = 0; k < SEG; k++) begin
            if (i_seg[(MSB_FIRST != 0) ? (SEG - 1 - k) : k]) begin
`ifdef PENC_MULTI_HIT_EN
                if (w_hit) begin
                    w_multi = 1'b1;
                end
`endif
                if (!w_hit) begin
                    w_hit = 1'b1;
                    w_loc = IW_MAX'((MSB_FIRST != 0) ? (SEG - 1 - k) : k);
                end
            end
        end
    end

    // Assemble the node; an empty segment reports idx=0 rather than its base.
    always_comb begin
        o_node     = '0;
        o_node.hit = w_hit;
        o_node.idx = w_hit ? (i_base + w_loc) : '0;
`ifdef PENC_MULTI_HIT_EN
        o_node.multi = w_multi;
`endif
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Fully pipelined W-bit priority encoder: input register, per-segment encode,
// then a binary merge tree with one register level per tree level.
// Latency is 2 + log2(W/SEG) enabled cycles; ce freezes the whole pipe and a
// synchronous active-low reset (priority over ce) flushes every register.
// Build option: PENC_MULTI_HIT_EN adds the out_multi port and its pipeline.
module prio_encoder_pipe
    import penc_pkg::*;
#(
    parameter int W         = 64,
    parameter int SEG       = 16,
    parameter int MSB_FIRST = 0,
    localparam int IW       = penc_idx_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [W-1:0]  in,
    output logic          out_valid,
    output logic          out_hit,
`ifdef PENC_MULTI_HIT_EN
    output logic          out_multi,
`endif
    output logic [IW-1:0] out_idx
);

    localparam int NSEG = W / SEG;
    localparam int LV   = penc_clog2(NSEG);

    if ((SEG < 2) || ((SEG & (SEG - 1)) != 0) || ((W % SEG) != 0) ||
        ((NSEG & (NSEG - 1)) != 0) || (IW > IW_MAX)) begin : g_bad_cfg
        $error("prio_encoder_pipe: unsupported W/SEG combination");
    end

    logic          r_v0;
    logic [W-1:0]  r_in;
    logic [LV:0]   r_vld;
    penc_node_t    w_seg  [NSEG];
    penc_node_t    r_tree [0:LV][0:NSEG-1];
    penc_node_t    w_root;

    // Stage 0: capture the request word and its valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_in <= '0;
        end else if (ce) begin
            r_v0 <= in_valid;
            r_in <= in;
        end
    end

    // Valid bits shadow the data through stage 1 and every merge level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (ce) begin
            r_vld[0] <= r_v0;
            for (int l = 1; l <= LV; l++) begin
                r_vld[l] <= r_vld[l-1];
            end
        end
    end

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        penc_seg #(
            .SEG       (SEG),
            .MSB_FIRST (MSB_FIRST)
        ) u_seg (
            .i_seg  (r_in[s*SEG +: SEG]),
            .i_base (IW_MAX'(s * SEG)),
            .o_node (w_seg[s])
        );

        // Stage 1: register the per-segment node.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_tree[0][s] <= '0;
            end else if (ce) begin
                r_tree[0][s] <= w_seg[s];
            end
        end
    end

    // Level l holds NSEG>>l live nodes; the remaining slots of the row are tied to zero.
    for (genvar l = 1; l <= LV; l++) begin : g_lvl
        for (genvar j = 0; j < NSEG; j++) begin : g_node
            if (j < (NSEG >> l)) begin : g_used
                // Merge the adjacent lower/higher pair from the previous level.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_tree[l][j] <= '0;
                    end else if (ce) begin
                        r_tree[l][j] <= penc_merge(r_tree[l-1][2*j], r_tree[l-1][2*j+1],
                                                   MSB_FIRST != 0);
                    end
                end
            end else begin : g_pad
                // Unused slot in this row of the tree.
                always_ff @(posedge clk) begin
                    r_tree[l][j] <= '0;
                end
            end
        end
    end

    assign w_root    = r_tree[LV][0];
    assign out_valid = r_vld[LV];
    assign out_hit   = w_root.hit;
    assign out_idx   = w_root.idx[IW-1:0];
`ifdef PENC_MULTI_HIT_EN
    assign out_multi = w_root.multi;
`endif

    if (IW < IW_MAX) begin : g_idx_hi
        logic w_unused_idx_hi;
        assign w_unused_idx_hi = ^w_root.idx[IW_MAX-1:IW];
    end

endmodule

// File: doc/prio_encoder_pipe.md
# prio_encoder_pipe

Parametrised, fully pipelined priority encoder for the vision datapath. It accepts one W-bit request word per cycle and returns the index of the winning set bit. The winner is the lowest or the highest set bit, selected at elaboration time. It also reports whether any bit was set. It replaces fixed-width one-hot encoders: the result is correct for arbitrary (multi-hot) inputs, and the block adds valid tracking, clock-enable stalls and reset.

## Interface
Parameters:
- W, 64, input word width; must be a multiple of SEG.
- SEG, 16, segment width; power of two, at least 2.
- MSB_FIRST, 0, selects the winner: 0 = lowest set index wins, 1 = highest set index wins.
- Derived: NSEG = W/SEG, must be a power of two ≥ 1; IW = clog2(W), minimum 1.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- ce  in  1  pipeline clock enable.
- in_valid  in  1  qualifies in.
- in  in  W  request word.
- out_valid  out  1  qualifies the outputs.
- out_hit  out  1  at least one bit of the word was set.
- out_idx  out  IW  index of the winning bit; 0 when out_hit=0.
- out_multi  out  1  more than one bit was set; only present with PENC_MULTI_HIT_EN.

## Operation
- Stage 0 registers in and in_valid.
- Stage 1 encodes each segment s independently into {hit, multi, idx}. idx is the global index: s*SEG + local winner.
- Merge stages: a binary tree with one level per stage and log2(NSEG) levels. Each node combines a lower-index group a with a higher-index group b:
  - hit = a.hit | b.hit.
  - MSB_FIRST=0: idx = a.hit ? a.idx : b.idx.
  - MSB_FIRST=1: idx = b.hit ? b.idx : a.idx.
  - multi = a.multi | b.multi | (a.hit & b.hit).
- Empty word: out_hit=0, out_idx=0, out_multi=0, out_valid=1. It is still a valid result.
- in_valid travels alongside the data. Data registers load regardless of valid; outputs are only meaningful when out_valid=1.
- ce=0 freezes every pipeline register, including the valid bits. ce=0 does not drop or duplicate words.
- rst_n=0 has priority over ce. At the clock edge it clears every valid and data register to 0. In-flight words are discarded and never emerge.

## Timing
- Latency L = 2 + log2(NSEG) ce-enabled cycles from in to outputs. The default configuration gives L = 4. NSEG=1 gives L = 2.
- Throughput is one word per enabled cycle. There is no backpressure other than ce.
- Reset values: out_valid=0, out_hit=0, out_idx=0, out_multi=0. These hold from the first edge at which rst_n=0 is sampled.
- rst_n released: the first input can be captured on the same edge at which rst_n=1 is sampled.
- Outputs are driven directly from registers, with no combinational path from inputs to outputs.

## Configuration
- PENC_MULTI_HIT_EN defined: the out_multi port exists, and the multi field is carried through every stage at the same latency.
- Not defined: the out_multi port and all multi logic are absent.
- In both cases the other outputs are bit-identical.

## Structure
- Shared package penc_pkg:
  - clog2 function.
  - Node typedef struct {hit, multi, idx[IW_MAX-1:0]}, with multi omitted when PENC_MULTI_HIT_EN is undefined.
  - Merge function, parametrised by MSB_FIRST.
- Sub-module penc_seg: combinational SEG-bit encoder taking a segment base offset and producing one node.
  - Instantiated NSEG times in stage 1.
- The tree is a generate loop over levels in prio_encoder_pipe.

## Test plan
All scenarios use W=64, SEG=16, L=4.
- in=64'h1, in_valid=1 -> 4 cycles later out_valid=1, out_hit=1, out_idx=0, out_multi=0.
- in=64'h8000_0000_0001_0000 -> MSB_FIRST=0 gives out_idx=16; MSB_FIRST=1 gives out_idx=63; out_multi=1 in both cases.
- in=0, in_valid=1 -> out_valid=1, out_hit=0, out_idx=0, out_multi=0.
- Stream of 1<<k for k=0..63, one word per cycle -> out_idx runs 0..63 in order, out_valid high for 64 consecutive cycles.
- ce=0 for 3 cycles mid-stream -> outputs hold their values, then resume with no lost or repeated index.
- rst_n=0 for 1 cycle mid-stream -> next cycle all outputs are 0, and none of the pre-reset words ever appear.
